// File: rtl/jtkcpu_pkg.sv
// Shared definitions for the indexed-addressing sequencer.
// Holds postbyte mode/register/accumulator codes, the sequencer state
// encoding, the strobe-class encoding produced by the postbyte decoder and
// the write-back delta codes.
package jtkcpu_pkg;

    // Postbyte mode field [6:4]
    localparam logic [2:0] IDX_NOOFS    = 3'd0;
    localparam logic [2:0] IDX_OFS8     = 3'd1;
    localparam logic [2:0] IDX_OFS16    = 3'd2;
    localparam logic [2:0] IDX_ACC      = 3'd3;
    localparam logic [2:0] IDX_POSTINC1 = 3'd4;
    localparam logic [2:0] IDX_POSTINC2 = 3'd5;
    localparam logic [2:0] IDX_PREDEC1  = 3'd6;
    localparam logic [2:0] IDX_PREDEC2  = 3'd7;

    // Postbyte register field [2:0]; 7 is reserved and aliases X
    localparam logic [2:0] IDX_X   = 3'd0;
    localparam logic [2:0] IDX_Y   = 3'd1;
    localparam logic [2:0] IDX_U   = 3'd2;
    localparam logic [2:0] IDX_S   = 3'd3;
    localparam logic [2:0] IDX_PC  = 3'd4;
    localparam logic [2:0] IDX_DP  = 3'd5;
    localparam logic [2:0] IDX_EXT = 3'd6;

    // Accumulator select
    localparam logic [1:0] ACC_A = 2'd0;
    localparam logic [1:0] ACC_B = 2'd1;
    localparam logic [1:0] ACC_D = 2'd2;

    // Index write-back deltas (signed two's complement)
    localparam logic [2:0] DELTA_NONE = 3'b000;
    localparam logic [2:0] DELTA_P1   = 3'b001;
    localparam logic [2:0] DELTA_P2   = 3'b010;
    localparam logic [2:0] DELTA_M1   = 3'b111;
    localparam logic [2:0] DELTA_M2   = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OFS_HI,
        ST_OFS_LO,
        ST_CALC,
        ST_IND_HI,
        ST_IND_LO,
        ST_IND_LD,
        ST_DONE
    } idx_state_e;

    // Which adder strobe group fires in CALC
    typedef enum logic [2:0] {
        CLS_LD,     // ,R and post-increment: idx_ld
        CLS_OFS8,   // idx_8 (+idx_pc)
        CLS_OFS16,  // idx_16 (+idx_pc)
        CLS_ACC,    // idx_acc + idx_ld
        CLS_DEC,    // pre-decrement: idx_8 with a constant negative offset
        CLS_DP,     // idx_dp
        CLS_EXT     // data2addr
    } idx_cls_e;

endpackage

// File: rtl/jtkcpu_idxseq_if.sv
// Bus between the indexed-addressing sequencer and its surroundings
// (main sequencer, memory read port, index address adder, register file).
//   start/din        : postbyte handoff and read data
//   rd_req/rd_ind/rd_ack : byte read handshake
//   ofs_data, idx_sel, racc_sel, idx_* strobes, data2addr : adder control
//   upd_we/upd_delta : index register write-back
//   busy/done        : status to the main sequencer
// master = sequencer side, slave = environment side.
interface jtkcpu_idxseq_if;
    logic        start;
    logic [7:0]  din;
    logic        rd_req;
    logic        rd_ind;
    logic        rd_ack;
    logic [15:0] ofs_data;
    logic [2:0]  idx_sel;
    logic [1:0]  racc_sel;
    logic        idx_ld;
    logic        idx_8;
    logic        idx_16;
    logic        idx_acc;
    logic        idx_pc;
    logic        idx_dp;
    logic        data2addr;
    logic        upd_we;
    logic [2:0]  upd_delta;
    logic        busy;
    logic        done;

    modport master (
        input  start, din, rd_ack,
        output rd_req, rd_ind, ofs_data, idx_sel, racc_sel,
               idx_ld, idx_8, idx_16, idx_acc, idx_pc, idx_dp, data2addr,
               upd_we, upd_delta, busy, done
    );

    modport slave (
        output start, din, rd_ack,
        input  rd_req, rd_ind, ofs_data, idx_sel, racc_sel,
               idx_ld, idx_8, idx_16, idx_acc, idx_pc, idx_dp, data2addr,
               upd_we, upd_delta, busy, done
    );
endinterface

// File: rtl/jtkcpu_idxdec.sv
// Combinational postbyte decoder.
//   postbyte : indexed-mode postbyte
//   nbytes   : offset bytes to fetch from the PC stream (0..2)
//   cls      : strobe group to fire in CALC
//   idx_sel  : index register (7 folded onto X)
//   racc_sel : accumulator for accumulator-offset modes
//   delta    : write-back delta, DELTA_NONE when no write-back
//   indirect : postbyte bit 7
module jtkcpu_idxdec
    import jtkcpu_pkg::*;
(
    input  logic [7:0] postbyte,
    output logic [1:0] nbytes,
    output idx_cls_e   cls,
    output logic [2:0] idx_sel,
    output logic [1:0] racc_sel,
    output logic [2:0] delta,
    output logic       indirect
);

    logic [2:0] mode;
    logic [2:0] rsel;

    always_comb begin
        mode     = postbyte[6:4];
        rsel     = (postbyte[2:0] == 3'd7) ? IDX_X : postbyte[2:0];
        indirect = postbyte[7];
        nbytes   = 2'd0;
        cls      = CLS_LD;
        idx_sel  = rsel;
        racc_sel = ACC_A;
        delta    = DELTA_NONE;

        if (rsel == IDX_DP) begin
            nbytes  = 2'd1;
            cls     = CLS_DP;
            idx_sel = IDX_X;
        end else if (rsel == IDX_EXT) begin
            nbytes  = 2'd2;
            cls     = CLS_EXT;
            idx_sel = IDX_X;
        end else if (rsel == IDX_PC && mode > IDX_OFS16) begin
            // PC only supports ,R / 8-bit / 16-bit; anything else is a plain ,PC
            cls = CLS_LD;
        end else begin
            case (mode)
                IDX_NOOFS: begin
                    if (postbyte[3]) begin
                        cls      = CLS_ACC;
                        racc_sel = ACC_D;
                    end
                end
                IDX_OFS8: begin
                    nbytes = 2'd1;
                    cls    = CLS_OFS8;
                end
                IDX_OFS16: begin
                    nbytes = 2'd2;
                    cls    = CLS_OFS16;
                end
                IDX_ACC: begin
                    cls      = CLS_ACC;
                    racc_sel = postbyte[3] ? ACC_B : ACC_A;
                end
                IDX_POSTINC1: delta = DELTA_P1;
                IDX_POSTINC2: delta = DELTA_P2;
                IDX_PREDEC1: begin
                    cls   = CLS_DEC;
                    delta = DELTA_M1;
                end
                IDX_PREDEC2: begin
                    cls   = CLS_DEC;
                    delta = DELTA_M2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jtkcpu_idxseq.sv
// Indexed-addressing sequencer feeding the index address adder.
// Takes the postbyte on start, fetches offset bytes from the PC stream,
// fires one adder strobe group, optionally fetches an indirect pointer from
// the computed address, and signals done.
//   clk, rst : clock, synchronous active-high reset
//   cen      : clock enable; qualifies all state updates and gates strobes
//   bus      : jtkcpu_idxseq_if master side (see interface header)
module jtkcpu_idxseq
    import jtkcpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    jtkcpu_idxseq_if.master  bus
);

    logic [1:0] dec_nbytes;
    idx_cls_e   dec_cls;
    logic [2:0] dec_sel;
    logic [1:0] dec_racc;
    logic [2:0] dec_delta;
    logic       dec_ind;

    jtkcpu_idxdec u_dec (
        .postbyte (bus.din),
        .nbytes   (dec_nbytes),
        .cls      (dec_cls),
        .idx_sel  (dec_sel),
        .racc_sel (dec_racc),
        .delta    (dec_delta),
        .indirect (dec_ind)
    );

    idx_state_e  state;
    idx_cls_e    cls_q;
    logic        ind_q;
    logic [2:0]  sel_q;
    logic [1:0]  racc_q;
    logic [2:0]  delta_q;
    logic [15:0] ofs_q;
    logic        busy_q, done_q, rd_req_q, rd_ind_q, upd_q;
    logic        ld_q, i8_q, i16_q, acc_q, pc_q, dp_q, d2a_q;

    // CALC can be entered straight from IDLE (decoder still on din) or from
    // OFS_LO (fields already latched), so pick the matching source.
    idx_cls_e    calc_cls;
    logic [2:0]  calc_sel;
    logic [2:0]  calc_delta;
    logic        enter_calc;

    always_comb begin
        if (state == ST_IDLE) begin
            calc_cls   = dec_cls;
            calc_sel   = dec_sel;
            calc_delta = dec_delta;
        end else begin
            calc_cls   = cls_q;
            calc_sel   = sel_q;
            calc_delta = delta_q;
        end
        enter_calc = (state == ST_IDLE   && bus.start && dec_nbytes == 2'd0) ||
                     (state == ST_OFS_LO && bus.rd_ack);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cls_q    <= CLS_LD;
            ind_q    <= 1'b0;
            sel_q    <= '0;
            racc_q   <= '0;
            delta_q  <= '0;
            ofs_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_req_q <= 1'b0;
            rd_ind_q <= 1'b0;
            upd_q    <= 1'b0;
            {ld_q, i8_q, i16_q, acc_q, pc_q, dp_q, d2a_q} <= '0;
        end else if (cen) begin
            {ld_q, i8_q, i16_q, acc_q, pc_q, dp_q, d2a_q, upd_q, done_q} <= '0;

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q  <= 1'b1;
                        cls_q   <= dec_cls;
                        ind_q   <= dec_ind;
                        sel_q   <= dec_sel;
                        racc_q  <= dec_racc;
                        delta_q <= dec_delta;
                        // pre-decrement reuses the 8-bit path with -1/-2
                        if (dec_cls == CLS_DEC)
                            ofs_q <= {8'h00, (dec_delta == DELTA_M1) ? 8'hFF : 8'hFE};
                        else
                            ofs_q <= '0;
                        case (dec_nbytes)
                            2'd2: begin
                                state    <= ST_OFS_HI;
                                rd_req_q <= 1'b1;
                            end
                            2'd1: begin
                                state    <= ST_OFS_LO;
                                rd_req_q <= 1'b1;
                            end
                            default: state <= ST_CALC;
                        endcase
                    end
                end
                ST_OFS_HI: begin
                    if (bus.rd_ack) begin
                        ofs_q[15:8] <= bus.din;
                        state       <= ST_OFS_LO;
                    end
                end
                ST_OFS_LO: begin
                    if (bus.rd_ack) begin
                        ofs_q[7:0] <= bus.din;
                        rd_req_q   <= 1'b0;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (ind_q) begin
                        state    <= ST_IND_HI;
                        rd_req_q <= 1'b1;
                        rd_ind_q <= 1'b1;
                    end else begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_IND_HI: begin
                    if (bus.rd_ack) begin
                        ofs_q[15:8] <= bus.din;
                        state       <= ST_IND_LO;
                    end
                end
                ST_IND_LO: begin
                    if (bus.rd_ack) begin
                        ofs_q[7:0] <= bus.din;
                        rd_req_q   <= 1'b0;
                        rd_ind_q   <= 1'b0;
                        d2a_q      <= 1'b1;
                        state      <= ST_IND_LD;
                    end
                end
                ST_IND_LD: begin
                    state  <= ST_DONE;
                    done_q <= 1'b1;
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (enter_calc) begin
                case (calc_cls)
                    CLS_LD:    ld_q <= 1'b1;
                    CLS_OFS8: begin
                        i8_q <= 1'b1;
                        pc_q <= (calc_sel == IDX_PC);
                    end
                    CLS_OFS16: begin
                        i16_q <= 1'b1;
                        pc_q  <= (calc_sel == IDX_PC);
                    end
                    CLS_ACC: begin
                        acc_q <= 1'b1;
                        ld_q  <= 1'b1;
                    end
                    CLS_DEC:   i8_q  <= 1'b1;
                    CLS_DP:    dp_q  <= 1'b1;
                    CLS_EXT:   d2a_q <= 1'b1;
                    default:   ld_q  <= 1'b1;
                endcase
                upd_q <= (calc_delta != DELTA_NONE);
            end
        end
    end

    // Strobes and read requests are only presented on enabled cycles, so a
    // frozen cycle neither fires the adder nor invites an unusable ack.
    assign bus.rd_req    = rd_req_q & cen;
    assign bus.rd_ind    = rd_ind_q;
    assign bus.ofs_data  = ofs_q;
    assign bus.idx_sel   = sel_q;
    assign bus.racc_sel  = racc_q;
    assign bus.idx_ld    = ld_q  & cen;
    assign bus.idx_8     = i8_q  & cen;
    assign bus.idx_16    = i16_q & cen;
    assign bus.idx_acc   = acc_q & cen;
    assign bus.idx_pc    = pc_q  & cen;
    assign bus.idx_dp    = dp_q  & cen;
    assign bus.data2addr = d2a_q & cen;
    assign bus.upd_we    = upd_q & cen;
    assign bus.upd_delta = delta_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q & cen;

endmodule
